// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing a 4-bit 2:1 nibble MUX between
//               requesters A and B. Drives the MUX select and registers the
//               selected nibble into a single valid/ready output slot.
//               A grant lasts up to MAX_BURST accepted beats.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [3:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [3:0] b_data,
    output logic       b_ready,
    output logic       mux_sel,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_src,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // Burst count value at which the next accepted beat ends the grant.
    localparam logic [3:0] c_last_beat = 4'(MAX_BURST - 1);

    // Requester encoding used by r_last and out_src: 1 = A, 0 = B.
    localparam logic c_req_a = 1'b1;
    localparam logic c_req_b = 1'b0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_nxt;

    logic       r_out_valid;
    logic [3:0] r_out_data;
    logic       r_out_src;

    logic       w_slot_free;
    logic       w_accept;
    logic       w_cur_valid;
    logic       w_oth_valid;
    logic       w_release;
    logic [3:0] w_mux_data;

    assign w_slot_free = !r_out_valid || out_ready;
    assign mux_sel     = (r_state == GNT_A);
    assign a_ready     = (r_state == GNT_A) && w_slot_free;
    assign b_ready     = (r_state == GNT_B) && w_slot_free;
    assign w_accept    = (a_valid && a_ready) || (b_valid && b_ready);
    assign w_mux_data  = mux_sel ? a_data : b_data;

    // The granted side's valid and the waiting side's valid; only meaningful
    // in a grant state. Backpressure blocks accepts, so it also freezes the
    // burst count and suppresses burst-limit release without extra logic.
    assign w_cur_valid = mux_sel ? a_valid : b_valid;
    assign w_oth_valid = mux_sel ? b_valid : a_valid;
    assign w_release   = (w_accept && (r_burst_cnt == c_last_beat)) || !w_cur_valid;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

    // Arbitration state register: state, last granted requester, burst count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= c_req_b;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Next-state logic: tie-break on last in IDLE, direct handoff on release.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (a_valid && (!b_valid || (r_last == c_req_b))) begin
                    w_state_nxt = GNT_A;
                    w_last_nxt  = c_req_a;
                    w_burst_nxt = 4'd0;
                end else if (b_valid) begin
                    w_state_nxt = GNT_B;
                    w_last_nxt  = c_req_b;
                    w_burst_nxt = 4'd0;
                end
            end
            GNT_A, GNT_B: begin
                if (w_release) begin
                    w_burst_nxt = 4'd0;
                    if (w_oth_valid) begin
                        w_state_nxt = mux_sel ? GNT_B : GNT_A;
                        w_last_nxt  = mux_sel ? c_req_b : c_req_a;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_accept) begin
                    w_burst_nxt = r_burst_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_burst_nxt = 4'd0;
            end
        endcase
    end

    // Output slot: load on accept, empty on drain without a refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 4'h0;
            r_out_src   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_src   <= mux_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4-bit 2:1 nibble MUX between two requesters, A and B. It drives the MUX select and registers the selected nibble into a single output slot with valid/ready flow control. A granted requester keeps the MUX for a burst of up to MAX_BURST beats. The block sits directly upstream of the CMOV datapath consumer and replaces free-running select logic.

## Interface
- MAX_BURST, 4, maximum beats per grant before the grant is forced to rotate; legal range 1..15
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- a_valid  input  1  requester A holds a beat
- a_data  input  4  requester A nibble
- a_ready  output  1  beat on A accepted this cycle when a_valid && a_ready
- b_valid  input  1  requester B holds a beat
- b_data  input  4  requester B nibble
- b_ready  output  1  beat on B accepted this cycle when b_valid && b_ready
- mux_sel  output  1  MUX select; 1 selects A, 0 selects B
- out_valid  output  1  output slot holds a beat
- out_data  output  4  registered beat
- out_src  output  1  source of the held beat; 1 = A, 0 = B
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready

## Operation
- States: IDLE, GNT_A, GNT_B. Registers: state, last (last granted requester), burst_cnt (4 bits), and the output slot.
- mux_sel = (state == GNT_A). It is combinational from state, and out_data is loaded through the same select.
- slot_free = !out_valid || out_ready.
- a_ready = (state == GNT_A) && slot_free.
- b_ready = (state == GNT_B) && slot_free.
- Accept: on a_valid && a_ready (or b_valid && b_ready), load out_data with the granted requester's data, set out_src = mux_sel and out_valid = 1, and increment burst_cnt.
- Output drain: on out_valid && out_ready with no accept in the same cycle, out_valid goes to 0. Drain and accept in the same cycle leaves out_valid = 1 holding the new beat.
- IDLE behaviour:
  - Both valid: grant the requester that is not `last`.
  - One valid: grant that requester.
  - None valid: stay in IDLE.
  - On any grant, burst_cnt is set to 0 and last is updated to the granted requester.
- GNT_x release: the grant is released at a clock edge when either condition holds:
  - (a) a beat is accepted with burst_cnt == MAX_BURST-1, or
  - (b) x_valid == 0.
- GNT_x release target:
  - If the other requester is valid, move directly to its grant state. Set burst_cnt = 0 and last = other.
  - Otherwise go to IDLE.
- While out_valid && !out_ready, the grant holds, burst_cnt is frozen and no release by (a) occurs. Release by (b) still applies.
- A requester that drops valid mid-burst loses the grant. It re-arbitrates like a new request.
- burst_cnt never exceeds MAX_BURST-1. With MAX_BURST = 1, every accepted beat releases the grant.

## Timing
- Reset values (synchronous, rst_n low at a clock edge):
  - state = IDLE, last = B (so A wins the first tie), burst_cnt = 0.
  - out_valid = 0, out_data = 4'h0, out_src = 0.
  - Consequently mux_sel = 0, a_ready = 0, b_ready = 0.
- Reset mid-burst: the held beat is discarded and all registers take their reset values at that edge. The ready signals are 0 in the following cycle.
- Arbitration latency: a request seen in IDLE at edge N gives grant and ready in cycle N+1. The first accept is at edge N+1, and out_valid is visible in cycle N+2.
- Grant-to-grant handoff (release target valid) has no IDLE bubble. The other side's ready is asserted in the cycle after the release edge.
- Steady state: with out_ready held at 1, throughput is 1 beat per cycle within a burst.
- Combinational paths: ready depends combinationally on out_ready and state. No valid depends on ready.

## Test plan
- Reset, then a_valid = 1, a_data = 4'h5, B idle, out_ready = 1:
  - grant GNT_A after 1 cycle, mux_sel = 1;
  - out_data = 4'h5, out_src = 1 one cycle later.
- Both valid continuously, out_ready = 1, MAX_BURST = 4, A sends 1,2,3,4,5…, B sends 9,A,B,C,D…:
  - out_src sequence is 1,1,1,1,0,0,0,0,1,… with no gap cycles;
  - data is 1,2,3,4,9,A,B,C,5.
- GNT_A with A dropping valid after 2 beats while b_valid = 1:
  - next cycle mux_sel = 0, b_ready = 1, burst_cnt = 0.
- Backpressure: out_ready = 0 for 3 cycles after the first beat:
  - a_ready = 0 and out_data stays stable;
  - burst_cnt does not advance;
  - on out_ready = 1 the transfer resumes with no lost or duplicated beat.
- Tie after B last served, both valid from IDLE: grant goes to A.
- rst_n pulled low mid-burst with out_valid = 1: next cycle out_valid = 0, out_data = 4'h0, mux_sel = 0, both readys 0.
